// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
package riscv_ctrl_pkg;

  // Sequencer states; one instruction walks FETCH..WRITEBACK, TRAP is terminal.
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } ctrl_state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [2:0] F3_SR    = 3'b101;

  // The alternate ALU encoding (SUB/SRA) is only meaningful for R-type and
  // for the I-ALU shift-right form; ADDI never uses func7.
  function automatic logic alt_alu_op(input logic is_r, input logic is_ialu,
                                      input logic [2:0] func3, input logic [6:0] func7);
    logic alt;
    alt = 1'b0;
    if (func7 == F7_ALT) begin
      if (is_r) begin
        alt = 1'b1;
      end else if (is_ialu && (func3 == F3_SR)) begin
        alt = 1'b1;
      end else begin
        alt = 1'b0;
      end
    end else begin
      alt = 1'b0;
    end
    return alt;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle of IR fields, memory handshakes and datapath control strobes.
interface multicycle_controller_if #(parameter int INSTRET_W = 32);
  logic [6:0]           opcode;
  logic [2:0]           func3;
  logic [6:0]           func7;
  logic                 imem_req;
  logic                 imem_ready;
  logic                 dmem_req;
  logic                 dmem_ready;
  logic                 pcWrite;
  logic                 irWrite;
  logic                 regWrite;
  logic                 aluSrc;
  logic                 subsra;
  logic                 memRead;
  logic                 memWrite;
  logic                 memToReg;
  logic                 illegal;
  logic [INSTRET_W-1:0] instret;

  // Controller side.
  modport master (
    input  opcode, func3, func7, imem_ready, dmem_ready,
    output imem_req, dmem_req, pcWrite, irWrite, regWrite, aluSrc, subsra,
           memRead, memWrite, memToReg, illegal, instret
  );

  // Datapath / memory side.
  modport slave (
    output opcode, func3, func7, imem_ready, dmem_ready,
    input  imem_req, dmem_req, pcWrite, irWrite, regWrite, aluSrc, subsra,
           memRead, memWrite, memToReg, illegal, instret
  );
endinterface

// File: rtl/multicycle_controller_decoder.sv
// Purely combinational instruction-class decoder for the supported RV32I subset.
import riscv_ctrl_pkg::*;

module inst_class_decoder (
  input  logic [6:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic [6:0] func7_i,
  output logic       is_r_o,
  output logic       is_ialu_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_illegal_o,
  output logic       alt_op_o
);

  // Classify the opcode; anything outside the four classes is illegal.
  always_comb begin
    is_r_o       = 1'b0;
    is_ialu_o    = 1'b0;
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: is_r_o       = 1'b1;
      OP_IALU:  is_ialu_o    = 1'b1;
      OP_LOAD:  is_load_o    = 1'b1;
      OP_STORE: is_store_o   = 1'b1;
      default:  is_illegal_o = 1'b1;
    endcase
    alt_op_o = alt_alu_op(is_r_o, is_ialu_o, func3_i, func7_i);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with trap.
import riscv_ctrl_pkg::*;

module multicycle_controller #(
  parameter int INSTRET_W = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.master bus
);

  ctrl_state_t          state_q, state_d;
  logic                 started_q;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic is_r_s, is_ialu_s, is_load_s, is_store_s, is_illegal_s, alt_op_s;
  logic imem_req_s, dmem_req_s, pc_write_s, ir_write_s, reg_write_s;
  logic alu_src_s, subsra_s, mem_read_s, mem_write_s, mem_to_reg_s, illegal_s;
  logic retire_s;

  inst_class_decoder u_dec (
    .opcode_i     (bus.opcode),
    .func3_i      (bus.func3),
    .func7_i      (bus.func7),
    .is_r_o       (is_r_s),
    .is_ialu_o    (is_ialu_s),
    .is_load_o    (is_load_s),
    .is_store_o   (is_store_s),
    .is_illegal_o (is_illegal_s),
    .alt_op_o     (alt_op_s)
  );

  // State register; reset parks the sequencer in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Holds every output low until the first edge after reset release, so
  // imem_req only rises once the clock has actually run out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
    end
  end

  // Next-state logic; handshakes only advance while the matching request is up.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (started_q && bus.imem_ready) state_d = DECODE;
        else                              state_d = FETCH;
      end
      DECODE: begin
        if (is_illegal_s) state_d = TRAP;
        else              state_d = EXECUTE;
      end
      EXECUTE: begin
        if (is_load_s || is_store_s)   state_d = MEMORY;
        else if (is_r_s || is_ialu_s)  state_d = WRITEBACK;
        else                           state_d = TRAP;
      end
      MEMORY: begin
        if (!bus.dmem_ready)   state_d = MEMORY;
        else if (is_load_s)    state_d = WRITEBACK;
        else                   state_d = FETCH;
      end
      WRITEBACK: state_d = FETCH;
      TRAP:      state_d = TRAP;
      default:   state_d = FETCH;
    endcase
  end

  // An instruction retires when WRITEBACK ends or when a store completes.
  always_comb begin
    retire_s  = (state_q == WRITEBACK) ||
                ((state_q == MEMORY) && bus.dmem_ready && !is_load_s);
    if (retire_s) instret_d = instret_q + INSTRET_W'(1);
    else          instret_d = instret_q;
  end

  // Retired-instruction counter; wraps naturally at 2^INSTRET_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  // Moore outputs from state and IR class; only pcWrite/irWrite see imem_ready.
  always_comb begin
    imem_req_s   = 1'b0;
    dmem_req_s   = 1'b0;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_s    = 1'b0;
    subsra_s     = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    illegal_s    = 1'b0;
    if (started_q) begin
      case (state_q)
        FETCH: begin
          imem_req_s = 1'b1;
          ir_write_s = bus.imem_ready;
          pc_write_s = bus.imem_ready;
        end
        EXECUTE: begin
          alu_src_s = !is_r_s;
          subsra_s  = alt_op_s;
        end
        MEMORY: begin
          dmem_req_s  = 1'b1;
          mem_read_s  = is_load_s;
          mem_write_s = is_store_s;
          alu_src_s   = 1'b1;
        end
        WRITEBACK: begin
          reg_write_s  = 1'b1;
          mem_to_reg_s = is_load_s;
        end
        TRAP:    illegal_s = 1'b1;
        default: illegal_s = 1'b0;
      endcase
    end else begin
      illegal_s = 1'b0;
    end
  end

  assign bus.imem_req = imem_req_s;
  assign bus.dmem_req = dmem_req_s;
  assign bus.pcWrite  = pc_write_s;
  assign bus.irWrite  = ir_write_s;
  assign bus.regWrite = reg_write_s;
  assign bus.aluSrc   = alu_src_s;
  assign bus.subsra   = subsra_s;
  assign bus.memRead  = mem_read_s;
  assign bus.memWrite = mem_write_s;
  assign bus.memToReg = mem_to_reg_s;
  assign bus.illegal  = illegal_s;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed table, random instructions against a
// behavioural model, plus trap and mid-instruction reset sequences.
module tb_multicycle_controller;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         iw;     // imem wait cycles
    int         dw;     // dmem wait cycles
    int         cycles; // expected FETCH-to-FETCH latency
    int         alu;    // aluSrc in EXECUTE
    int         sub;    // subsra in EXECUTE
    int         rw;     // regWrite pulses
    int         m2r;    // memToReg pulses (with regWrite)
    int         mr;     // memRead cycles
    int         mw;     // memWrite cycles
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [31:0] exp_instret;

  multicycle_controller_if #(.INSTRET_W(32)) bus ();

  multicycle_controller #(.INSTRET_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: derives every expectation from the instruction class rules.
  function automatic vec_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input int iw, input int dw);
    vec_t v;
    bit r, ia, ld, st;
    r  = (op == 7'b0110011);
    ia = (op == 7'b0010011);
    ld = (op == 7'b0000011);
    st = (op == 7'b0100011);
    v.op = op; v.f3 = f3; v.f7 = f7; v.iw = iw; v.dw = dw;
    v.cycles = (iw + 1) + 1 + 1 + ((ld || st) ? dw + 1 : 0) + (st ? 0 : 1);
    v.alu = r ? 0 : 1;
    v.sub = ((f7 == 7'b0100000) && (r || (ia && f3 == 3'b101))) ? 1 : 0;
    v.rw  = st ? 0 : 1;
    v.m2r = ld ? 1 : 0;
    v.mr  = ld ? dw + 1 : 0;
    v.mw  = st ? dw + 1 : 0;
    return v;
  endfunction

  // Runs one instruction cycle by cycle, acting as both memories.
  task automatic run_instr(input vec_t v, input string tag);
    int icnt, dcnt, irw, pcw, rw, m2r, m2r_rw, mr, mw, alu, sub, ill;
    icnt = 0; dcnt = 0; irw = 0; pcw = 0; rw = 0; m2r = 0; m2r_rw = 0;
    mr = 0; mw = 0; alu = 0; sub = 0; ill = 0;
    bus.opcode = v.op;
    bus.func3  = v.f3;
    bus.func7  = v.f7;
    for (int c = 0; c < v.cycles; c++) begin
      @(negedge clk);
      bus.imem_ready = bus.imem_req ? (icnt == v.iw) : 1'($urandom_range(0, 1));
      bus.dmem_ready = bus.dmem_req ? (dcnt == v.dw) : 1'($urandom_range(0, 1));
      #1;
      if (c == 0) begin
        check({tag, " fetch_start"}, {31'd0, bus.imem_req}, 32'd1);
        check({tag, " instret_before"}, bus.instret, exp_instret);
      end
      if (c == v.iw + 2) begin
        check({tag, " exec_aluSrc"}, {31'd0, bus.aluSrc}, 32'(v.alu));
        check({tag, " exec_subsra"}, {31'd0, bus.subsra}, 32'(v.sub));
      end
      if (bus.imem_req) icnt++;
      if (bus.dmem_req) dcnt++;
      if (bus.irWrite && bus.imem_ready) irw++;
      if (bus.pcWrite && bus.imem_ready) pcw++;
      if (bus.regWrite) rw++;
      if (bus.memToReg) m2r++;
      if (bus.memToReg && bus.regWrite) m2r_rw++;
      if (bus.memRead && bus.dmem_req) mr++;
      if (bus.memWrite && bus.dmem_req) mw++;
      if (bus.aluSrc) alu++;
      if (bus.subsra) sub++;
      if (bus.illegal) ill++;
      @(posedge clk);
      #1;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
    end
    exp_instret = exp_instret + 32'd1;
    check({tag, " imem_req_cycles"}, 32'(icnt), 32'(v.iw + 1));
    check({tag, " dmem_req_cycles"}, 32'(dcnt), 32'(v.mr + v.mw));
    check({tag, " irWrite"}, 32'(irw), 32'd1);
    check({tag, " pcWrite"}, 32'(pcw), 32'd1);
    check({tag, " regWrite"}, 32'(rw), 32'(v.rw));
    check({tag, " memToReg"}, 32'(m2r), 32'(v.m2r));
    check({tag, " memToReg_wb"}, 32'(m2r_rw), 32'(v.m2r));
    check({tag, " memRead"}, 32'(mr), 32'(v.mr));
    check({tag, " memWrite"}, 32'(mw), 32'(v.mw));
    check({tag, " aluSrc_total"}, 32'(alu), 32'(v.alu + v.mr + v.mw));
    check({tag, " subsra_total"}, 32'(sub), 32'(v.sub));
    check({tag, " illegal"}, 32'(ill), 32'd0);
  endtask

  vec_t tbl[11];
  vec_t rv;
  logic [6:0] ops[4];
  int   cnt_req, cnt_ill, cnt_other;

  initial begin
    tests = 0;
    fails = 0;
    exp_instret = 32'd0;
    // op, f3, f7, iw, dw, cycles, alu, sub, rw, m2r, mr, mw
    tbl[0]  = '{7'b0110011, 3'b000, 7'b0100000, 0, 0, 4, 0, 1, 1, 0, 0, 0}; // SUB
    tbl[1]  = '{7'b0010011, 3'b000, 7'b0100000, 0, 0, 4, 1, 0, 1, 0, 0, 0}; // ADDI f7 alt
    tbl[2]  = '{7'b0010011, 3'b101, 7'b0100000, 0, 0, 4, 1, 1, 1, 0, 0, 0}; // SRAI
    tbl[3]  = '{7'b0000011, 3'b010, 7'b0000000, 0, 3, 8, 1, 0, 1, 1, 4, 0}; // LW, 3 waits
    tbl[4]  = '{7'b0100011, 3'b010, 7'b0000000, 0, 0, 4, 1, 0, 0, 0, 0, 1}; // SW
    tbl[5]  = '{7'b0110011, 3'b000, 7'b0000000, 2, 0, 6, 0, 0, 1, 0, 0, 0}; // ADD, fetch waits
    tbl[6]  = '{7'b0110011, 3'b101, 7'b0000000, 0, 0, 4, 0, 0, 1, 0, 0, 0}; // SRL
    tbl[7]  = '{7'b0110011, 3'b101, 7'b0100000, 0, 0, 4, 0, 1, 1, 0, 0, 0}; // SRA
    tbl[8]  = '{7'b0010011, 3'b101, 7'b0000000, 0, 0, 4, 1, 0, 1, 0, 0, 0}; // SRLI
    tbl[9]  = '{7'b0100011, 3'b000, 7'b0000000, 1, 2, 7, 1, 0, 0, 0, 0, 3}; // SB, waits
    tbl[10] = '{7'b0000011, 3'b000, 7'b0000000, 0, 0, 5, 1, 0, 1, 1, 1, 0}; // LB zero-wait

    rst_n = 1'b0;
    bus.opcode = 7'd0; bus.func3 = 3'd0; bus.func7 = 7'd0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    #7;
    check("reset imem_req", {31'd0, bus.imem_req}, 32'd0);
    check("reset instret", bus.instret, 32'd0);
    #4;  // t=11, just after a falling edge
    rst_n = 1'b1;
    #1;
    check("release imem_req_before_edge", {31'd0, bus.imem_req}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_instr(tbl[i], $sformatf("tbl%0d", i));
    end

    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
    for (int i = 0; i < 40; i++) begin
      logic [6:0] f7;
      int sel;
      sel = $urandom_range(0, 2);
      f7 = (sel == 0) ? 7'd0 : (sel == 1) ? 7'b0100000 : 7'($urandom_range(0, 127));
      rv = model(ops[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), f7,
                 $urandom_range(0, 3), $urandom_range(0, 3));
      run_instr(rv, $sformatf("rnd%0d", i));
    end

    // Reset during a LOAD stalled in MEMORY.
    bus.opcode = 7'b0000011; bus.func3 = 3'b010; bus.func7 = 7'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.imem_ready = bus.imem_req;
      bus.dmem_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.imem_ready = 1'b0;
    end
    @(negedge clk);
    #1;
    check("midload dmem_req", {31'd0, bus.dmem_req}, 32'd1);
    check("midload memRead", {31'd0, bus.memRead}, 32'd1);
    check("midload instret", bus.instret, exp_instret);
    rst_n = 1'b0;
    #1;
    check("midreset outs", {20'd0, bus.imem_req, bus.dmem_req, bus.pcWrite, bus.irWrite,
          bus.regWrite, bus.aluSrc, bus.subsra, bus.memRead, bus.memWrite,
          bus.memToReg, bus.illegal, 1'b0}, 32'd0);
    check("midreset instret", bus.instret, 32'd0);
    #1;
    rst_n = 1'b1;
    exp_instret = 32'd0;
    #1;
    check("midreset imem_req_before_edge", {31'd0, bus.imem_req}, 32'd0);
    @(posedge clk);
    #1;
    check("midreset imem_req_after_edge", {31'd0, bus.imem_req}, 32'd1);
    check("midreset regWrite", {31'd0, bus.regWrite}, 32'd0);
    run_instr(tbl[0], "post_midreset");

    // Illegal opcode: trap after DECODE, sticky, no further fetches.
    bus.opcode = 7'b1111111; bus.func3 = 3'd0; bus.func7 = 7'd0;
    cnt_req = 0; cnt_ill = 0; cnt_other = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      bus.imem_ready = bus.imem_req ? 1'b1 : 1'($urandom_range(0, 1));
      bus.dmem_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.imem_req) cnt_req++;
      if (bus.illegal) cnt_ill++;
      if (bus.dmem_req || bus.regWrite || bus.aluSrc || bus.subsra || bus.memRead ||
          bus.memWrite || bus.memToReg) cnt_other++;
      if (c == 1) check("trap decode_not_yet_illegal", {31'd0, bus.illegal}, 32'd0);
      @(posedge clk);
      #1;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
    end
    check("trap imem_req_cycles", 32'(cnt_req), 32'd1);
    check("trap illegal_cycles", 32'(cnt_ill), 32'd20);
    check("trap other_strobes", 32'(cnt_other), 32'd0);
    check("trap instret", bus.instret, exp_instret);
    rst_n = 1'b0;
    #1;
    check("trap reset illegal", {31'd0, bus.illegal}, 32'd0);
    check("trap reset instret", bus.instret, 32'd0);
    #2;
    rst_n = 1'b1;
    exp_instret = 32'd0;
    @(posedge clk);
    #1;
    check("trap release imem_req", {31'd0, bus.imem_req}, 32'd1);
    run_instr(tbl[4], "post_trap_store");
    run_instr(tbl[3], "post_trap_load");
    @(negedge clk);
    #1;
    check("final fetch", {31'd0, bus.imem_req}, 32'd1);
    check("final instret", bus.instret, exp_instret);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so a hung sequence still ends the run.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the RV32I core datapath. It replaces single-cycle control with an FSM that sequences each instruction through fetch, decode, execute, memory and writeback. Instruction and data memories use valid/ready handshakes. It drives the register-file, ALU, PC, IR and memory enables. It keeps a retired-instruction counter and traps on unsupported opcodes.

## Interface
- INSTRET_W, default 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction bits [6:0] from IR
- func3  in  3  instruction bits [14:12] from IR
- func7  in  7  instruction bits [31:25] from IR
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  instruction word valid this cycle
- dmem_req  out  1  data memory request
- dmem_ready  in  1  data access complete this cycle
- pcWrite  out  1  PC <= PC+4 strobe
- irWrite  out  1  IR load strobe
- regWrite  out  1  register-file write enable
- aluSrc  out  1  0 = rs2, 1 = immediate
- subsra  out  1  ALU SUB/SRA select
- memRead  out  1  load access; qualified by dmem_req
- memWrite  out  1  store access; qualified by dmem_req
- memToReg  out  1  writeback source; 0 = ALU, 1 = memory
- illegal  out  1  trap flag, sticky until reset
- instret  out  INSTRET_W  retired-instruction count

## Operation
- Supported classes:
  - R-type 0110011
  - I-ALU 0010011
  - LOAD 0000011
  - STORE 0100011
  - Any other opcode is illegal.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- FETCH: imem_req=1 until imem_ready. In the imem_ready cycle irWrite=1 and pcWrite=1 for exactly that one cycle, then go to DECODE.
- DECODE: one cycle; the register file is read.
  - Illegal opcode: go to TRAP.
  - Otherwise: go to EXECUTE.
- EXECUTE: one cycle.
  - aluSrc=0 for R-type; aluSrc=1 for I-ALU, LOAD and STORE.
  - subsra=1 for R-type with func7=0100000.
  - subsra=1 for I-ALU with func3=101 and func7=0100000 (SRAI).
  - subsra=0 for all other cases, including ADDI regardless of func7.
  - R-type and I-ALU go to WRITEBACK; LOAD and STORE go to MEMORY.
- MEMORY: dmem_req=1. memRead=1 for LOAD, memWrite=1 for STORE. These are held until and including the dmem_ready cycle, and aluSrc=1 is held throughout.
  - LOAD goes to WRITEBACK.
  - STORE goes to FETCH and increments instret.
- WRITEBACK: regWrite=1 for one cycle, memToReg=1 for LOAD only. Increment instret, then go to FETCH.
- TRAP: illegal=1; all strobes and requests are 0. Stays in TRAP until rst_n is asserted.
- instret wraps modulo 2^INSTRET_W with no saturation.
- Signals not listed for a state are 0 in that state.

## Timing
- Reset (async, rst_n=0):
  - State goes to FETCH and instret goes to 0.
  - All outputs are 0 while reset is held, including imem_req.
  - imem_req rises in the first clk edge after rst_n deasserts.
- Outputs are Moore from state and IR fields. Exception: irWrite and pcWrite are imem_ready-qualified in FETCH.
- Handshake:
  - A request stays asserted with stable qualifiers until ready is seen on a rising edge.
  - A ready seen while the request is low is ignored.
- Zero-wait latency, measured from the first FETCH cycle to the return to FETCH:
  - R-type and I-ALU: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Every wait cycle on imem_ready or dmem_ready adds exactly one cycle.
- instret updates on the edge that leaves WRITEBACK, or that leaves MEMORY for a STORE.
- rst_n asserted mid-instruction: state goes to FETCH immediately. The partial instruction is not counted and no write strobe is issued after reset.

## Structure
- Package riscv_ctrl_pkg holds:
  - The state enum ctrl_state_t.
  - Opcode constants OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE.
  - The constant F7_ALT = 7'b0100000.
- Sub-module inst_class_decoder is purely combinational. It maps opcode/func3/func7 to is_r, is_ialu, is_load, is_store, is_illegal and alt_op. The FSM stays in multicycle_controller.

## Test plan
- R-type SUB (opcode 0110011, func7 0100000), zero-wait memories:
  - Visits FETCH, DECODE, EXECUTE, WRITEBACK.
  - subsra=1 and aluSrc=0 in EXECUTE.
  - regWrite pulses in cycle 4, and instret goes 0 to 1.
- ADDI with func7=0100000 then SRAI (func3=101, func7=0100000):
  - ADDI gives subsra=0.
  - SRAI gives subsra=1.
  - aluSrc=1 for both.
- LOAD with dmem_ready delayed 3 cycles:
  - dmem_req and memRead are held for 4 cycles.
  - memToReg=1 with regWrite in WRITEBACK.
  - Total of 8 cycles.
- STORE, zero-wait:
  - memWrite=1 for one cycle.
  - regWrite is never asserted.
  - instret increments on leaving MEMORY.
  - Total of 4 cycles.
- Opcode 1111111:
  - Goes to TRAP after DECODE, and illegal=1 stays sticky.
  - imem_req stays 0 for 20 cycles.
  - rst_n pulse returns the block to FETCH with illegal=0.
- rst_n dropped in LOAD MEMORY with dmem_ready low:
  - All outputs go to 0 asynchronously and instret reads 0.
  - After release, imem_req=1 in the next cycle.
